cam_sensor_emu: RTL and testbench

CAM_SENSOR_EMU -- requirements
Module: cam_sensor_emu

---
 rtl/cam_pkg.sv | 37 +++
 rtl/cam_sensor_emu_if.sv | 22 ++
 rtl/cam_timing_cnt.sv | 50 +++++
 rtl/cam_sensor_emu.sv | 98 +++++++++
 tb/tb_cam_sensor_emu.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera sensor emulator: FSM states,
// pixel byte values, default timing and a counter-width helper.
package cam_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_t;

  localparam logic [7:0] BYTE0_VAL = 8'h80;
  localparam logic [7:0] BAR0_VAL  = 8'h20;
  localparam logic [7:0] BAR1_VAL  = 8'h60;
  localparam logic [7:0] BAR2_VAL  = 8'hA0;
  localparam logic [7:0] BAR3_VAL  = 8'hE0;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_TOTAL     = 784;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_TOTAL     = 510;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BP        = 17;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] bar_value(input logic [1:0] band);
    case (band)
      2'd0: return BAR0_VAL;
      2'd1: return BAR1_VAL;
      2'd2: return BAR2_VAL;
      2'd3: return BAR3_VAL;
    endcase
  endfunction

endpackage

// File: rtl/cam_sensor_emu_if.sv
// Video bus between the emulated sensor (master) and its consumer (slave).
interface cam_sensor_emu_if;

  logic       enable;
  logic       pclk;
  logic       v_sync;
  logic       h_ref;
  logic [7:0] data_out;
  logic       frame_done;
  logic [7:0] frame_cnt;

  modport master (
    input  enable,
    output pclk, v_sync, h_ref, data_out, frame_done, frame_cnt
  );

  modport slave (
    output enable,
    input  pclk, v_sync, h_ref, data_out, frame_done, frame_cnt
  );

endinterface

// File: rtl/cam_timing_cnt.sv
// Byte-slot and line counters for one frame; exposes the slot that will be
// shown after the current edge plus the end-of-frame wrap flag.
module cam_timing_cnt
  import cam_pkg::*;
#(
  parameter int  H_TOTAL = DEF_H_TOTAL,
  parameter int  V_TOTAL = DEF_V_TOTAL,
  localparam int BW      = cnt_width(2 * H_TOTAL),
  localparam int LW      = cnt_width(V_TOTAL)
) (
  input  logic          clk_25,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [BW-1:0] nxt_byte,
  output logic [LW-1:0] nxt_line,
  output logic          line_wrap
);

  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic          byte_wrap;

  assign byte_wrap = advance && (byte_cnt == BW'(2 * H_TOTAL - 1));
  assign line_wrap = byte_wrap && (line_cnt == LW'(V_TOTAL - 1));

  always_comb begin
    nxt_byte = byte_cnt;
    nxt_line = line_cnt;
    if (clear) begin
      nxt_byte = '0;
      nxt_line = '0;
    end else if (advance) begin
      nxt_byte = byte_wrap ? '0 : byte_cnt + BW'(1);
      if (byte_wrap)
        nxt_line = line_wrap ? '0 : line_cnt + LW'(1);
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else begin
      byte_cnt <= nxt_byte;
      line_cnt <= nxt_line;
    end
  end

endmodule

// File: rtl/cam_sensor_emu.sv
// Camera sensor emulator: pclk = clk_25/2, DVP-style v_sync/h_ref/data_out.
// Define CAM_EMU_TESTBAR_EN to send vertical colour bars instead of an x ramp.
module cam_sensor_emu
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BP        = DEF_V_BP
) (
  input logic              clk_25,
  input logic              reset_n,
  cam_sensor_emu_if.master bus
);

  localparam int BW = cnt_width(2 * H_TOTAL);
  localparam int LW = cnt_width(V_TOTAL);

  state_t        state, nxt_state;
  logic          advance, line_wrap, run_next;
  logic          nxt_vsync, nxt_href;
  logic [BW-1:0] nxt_byte;
  logic [LW-1:0] nxt_line;
  logic [31:0]   byte_i, line_i;
  logic [7:0]    byte1, nxt_data;

  // Slots advance on the clk_25 edge where pclk falls.
  assign advance = (state == ST_FRAME) && bus.pclk;

  cam_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .clear     (state == ST_IDLE),
    .advance   (advance),
    .nxt_byte  (nxt_byte),
    .nxt_line  (nxt_line),
    .line_wrap (line_wrap)
  );

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (bus.enable) nxt_state = ST_FRAME;
      ST_FRAME: if (line_wrap && !bus.enable) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // Decode the slot that becomes visible after this edge; between slot
  // advances the decode is unchanged, so registering every cycle is safe.
  always_comb begin
    byte_i    = 32'(nxt_byte);
    line_i    = 32'(nxt_line);
    run_next  = (nxt_state == ST_FRAME);
    nxt_vsync = run_next && (line_i < VSYNC_LINES);
    nxt_href  = run_next
                && (line_i >= VSYNC_LINES + V_BP)
                && (line_i <  VSYNC_LINES + V_BP + V_ACTIVE)
                && (byte_i <  2 * H_ACTIVE);
`ifdef CAM_EMU_TESTBAR_EN
    byte1 = bar_value(2'(((byte_i >> 1) * 4) / H_ACTIVE));
`else
    byte1 = 8'(byte_i >> 1);
`endif
    nxt_data = 8'h00;
    if (nxt_href)
      nxt_data = byte_i[0] ? byte1 : BYTE0_VAL;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      bus.pclk       <= 1'b0;
      bus.v_sync     <= 1'b0;
      bus.h_ref      <= 1'b0;
      bus.data_out   <= 8'h00;
      bus.frame_done <= 1'b0;
      bus.frame_cnt  <= 8'h00;
    end else begin
      bus.pclk       <= (state == ST_FRAME && nxt_state == ST_FRAME) ? ~bus.pclk : 1'b0;
      bus.v_sync     <= nxt_vsync;
      bus.h_ref      <= nxt_href;
      bus.data_out   <= nxt_data;
      bus.frame_done <= line_wrap;
      bus.frame_cnt  <= bus.frame_cnt + 8'(line_wrap);
    end
  end

endmodule

// File: tb/tb_cam_sensor_emu.sv
// Directed bench for cam_sensor_emu with a small frame (8x4 active, 12x8 total).
module tb_cam_sensor_emu;

  logic clk_25 = 1'b0;
  logic reset_n;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   k;

  // Line of 24 slots: 8 pixels of (0x80, byte1) then 8 blanking slots.
`ifdef CAM_EMU_TESTBAR_EN
  logic [7:0] exp_data [24] = '{8'h80, 8'h20, 8'h80, 8'h20, 8'h80, 8'h60, 8'h80, 8'h60,
                                8'h80, 8'hA0, 8'h80, 8'hA0, 8'h80, 8'hE0, 8'h80, 8'hE0,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
  logic [7:0] exp_data [24] = '{8'h80, 8'h00, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03,
                                8'h80, 8'h04, 8'h80, 8'h05, 8'h80, 8'h06, 8'h80, 8'h07,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
  logic [23:0] exp_href = 24'h00FFFF;

  cam_sensor_emu_if bus();

  cam_sensor_emu #(
    .H_ACTIVE    (8),
    .H_TOTAL     (12),
    .V_ACTIVE    (4),
    .V_TOTAL     (8),
    .VSYNC_LINES (1),
    .V_BP        (2)
  ) dut (
    .clk_25  (clk_25),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_25 = ~clk_25;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  // k counts negedges since the edge on which enable was last raised from IDLE.
  task automatic advance_to(input int target);
    wait_cycles(target - k);
    k = target;
  endtask

  // Video outputs must hold across every rising edge of pclk.
  always @(posedge clk_25) begin : rise_check
    logic       p0, v0, h0;
    logic [7:0] d0;
    p0 = bus.pclk;
    v0 = bus.v_sync;
    h0 = bus.h_ref;
    d0 = bus.data_out;
    #1;
    if (reset_n && !p0 && bus.pclk)
      check_output("stable_on_rise", {bus.v_sync, bus.h_ref, bus.data_out}, {v0, h0, d0});
  end

  initial begin
    reset_n    = 1'b1;
    bus.enable = 1'b0;
    k          = 0;
    #3 reset_n = 1'b0;
    #1;
    check_output("rst_pclk",       bus.pclk,       0);
    check_output("rst_v_sync",     bus.v_sync,     0);
    check_output("rst_h_ref",      bus.h_ref,      0);
    check_output("rst_data",       bus.data_out,   0);
    check_output("rst_frame_done", bus.frame_done, 0);
    check_output("rst_frame_cnt",  bus.frame_cnt,  0);

    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(3);
    check_output("idle_pclk",   bus.pclk,      0);
    check_output("idle_v_sync", bus.v_sync,    0);
    check_output("idle_h_ref",  bus.h_ref,     0);
    check_output("idle_cnt",    bus.frame_cnt, 0);

    bus.enable = 1'b1;
    k = -1;
    advance_to(0);
    check_output("f0_pclk0",   bus.pclk,     0);
    check_output("f0_v_sync",  bus.v_sync,   1);
    check_output("f0_h_ref",   bus.h_ref,    0);
    check_output("f0_data",    bus.data_out, 0);
    advance_to(1);
    check_output("f0_pclk1",   bus.pclk,     1);
    advance_to(47);
    check_output("vs_last",    bus.v_sync,   1);
    advance_to(48);
    check_output("vs_fall",    bus.v_sync,   0);
    advance_to(143);
    check_output("href_pre",   bus.h_ref,    0);

    for (int b = 0; b < 24; b++) begin
      advance_to(144 + 2 * b);
      check_output("line3_h_ref", bus.h_ref,    exp_href[b]);
      check_output("line3_data",  bus.data_out, exp_data[b]);
    end

    advance_to(383);
    check_output("f0_end_done", bus.frame_done, 0);
    check_output("f0_end_cnt",  bus.frame_cnt,  0);
    advance_to(384);
    check_output("f1_done",     bus.frame_done, 1);
    check_output("f1_cnt",      bus.frame_cnt,  1);
    check_output("f1_v_sync",   bus.v_sync,     1);
    check_output("f1_pclk",     bus.pclk,       0);
    advance_to(385);
    check_output("f1_done_off", bus.frame_done, 0);
    check_output("f1_pclk1",    bus.pclk,       1);

    advance_to(700);
    bus.enable = 1'b0;
    advance_to(740);
    bus.enable = 1'b1;
    advance_to(767);
    check_output("f2_pre_done", bus.frame_done, 0);
    advance_to(768);
    check_output("f2_done",     bus.frame_done, 1);
    check_output("f2_cnt",      bus.frame_cnt,  2);
    check_output("f2_v_sync",   bus.v_sync,     1);
    advance_to(1152);
    check_output("f3_done",     bus.frame_done, 1);
    check_output("f3_cnt",      bus.frame_cnt,  3);
    check_output("f3_v_sync",   bus.v_sync,     1);
    advance_to(1153);
    check_output("f3_pclk1",    bus.pclk,       1);

    advance_to(1300);
    bus.enable = 1'b0;
    advance_to(1535);
    check_output("f3_last_pclk", bus.pclk,       1);
    check_output("f3_last_done", bus.frame_done, 0);
    advance_to(1536);
    check_output("stop_done",   bus.frame_done, 1);
    check_output("stop_cnt",    bus.frame_cnt,  4);
    check_output("stop_pclk",   bus.pclk,       0);
    check_output("stop_v_sync", bus.v_sync,     0);
    check_output("stop_h_ref",  bus.h_ref,      0);
    check_output("stop_data",   bus.data_out,   0);
    advance_to(1537);
    check_output("stop_done_off", bus.frame_done, 0);
    advance_to(1540);
    check_output("stop_pclk_held", bus.pclk,      0);
    check_output("stop_cnt_held",  bus.frame_cnt, 4);

    bus.enable = 1'b1;
    k = -1;
    advance_to(0);
    check_output("re_v_sync", bus.v_sync, 1);
    check_output("re_pclk",   bus.pclk,   0);
    advance_to(202);
    check_output("l4s5_h_ref", bus.h_ref,    exp_href[5]);
    check_output("l4s5_data",  bus.data_out, exp_data[5]);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_rst_pclk",   bus.pclk,       0);
    check_output("mid_rst_v_sync", bus.v_sync,     0);
    check_output("mid_rst_h_ref",  bus.h_ref,      0);
    check_output("mid_rst_data",   bus.data_out,   0);
    check_output("mid_rst_done",   bus.frame_done, 0);
    check_output("mid_rst_cnt",    bus.frame_cnt,  0);

    wait_cycles(2);
    reset_n = 1'b1;
    k = -1;
    advance_to(0);
    check_output("post_v_sync", bus.v_sync,     1);
    check_output("post_pclk",   bus.pclk,       0);
    check_output("post_h_ref",  bus.h_ref,      0);
    check_output("post_done",   bus.frame_done, 0);
    check_output("post_cnt",    bus.frame_cnt,  0);
    advance_to(1);
    check_output("post_pclk1",  bus.pclk,       1);
    check_output("post_vs1",    bus.v_sync,     1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
